nanov_shift_seq: RTL and testbench

- Sequencer that runs one RV32 shift instruction (SLL/SRL/SRA) as a 32-cycle bit-serial operation.
- Latches the operands and steps a 5-bit bit counter over the per-bit shift slice, one result bit per cycle, LSB first.
- Emits the result bits as a serial stream and also assembles them into a parallel result.
- Sits between decode/issue and register writeback; requests and results use valid/ready handshakes.

---
 rtl/nanov_shift_seq_if.sv | 27 ++
 rtl/nanov_shift_seq.sv | 137 +++++++++++++
 tb/tb_nanov_shift_seq.sv | 340 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/nanov_shift_seq_if.sv
// Request, serial-stream and result signals of the bit-serial shift sequencer.
// The master modport is the issuing/consuming side; the slave modport is the sequencer.
interface nanov_shift_seq_if;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_op;
    logic [31:0] in_a;
    logic [4:0]  in_b;
    logic        abort;
    logic        bit_valid;
    logic        bit_out;
    logic        busy;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_d;
    logic        out_err;

    modport master (
        output in_valid, in_op, in_a, in_b, abort, out_ready,
        input  in_ready, bit_valid, bit_out, busy, out_valid, out_d, out_err
    );

    modport slave (
        input  in_valid, in_op, in_a, in_b, abort, out_ready,
        output in_ready, bit_valid, bit_out, busy, out_valid, out_d, out_err
    );
endinterface

// File: rtl/nanov_shift_seq.sv
// Bit-serial RV32 SLL/SRL/SRA sequencer: one result bit per cycle over 32 cycles,
// streamed LSB first and assembled into a parallel result.
module nanov_shift_seq #(
    parameter bit ZERO_SHAMT_FAST = 1'b0
) (
    input logic              clk,
    input logic              rst,
    nanov_shift_seq_if.slave bus
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic [3:0] OP_SLL = 4'b0001;
    localparam logic [3:0] OP_SRL = 4'b0101;
    localparam logic [3:0] OP_SRA = 4'b1101;

    logic [1:0]  state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] a_q, a_d;
    logic [4:0]  b_q, b_d;
    logic        right_q, right_d;
    logic        fill_q, fill_d;
    logic [31:0] res_q, res_d;
    logic        err_q, err_d;

    logic        op_legal;
    logic [5:0]  pos_sum;
    logic        shift_bit;
    logic        shift_en;

    // Only the direction and the fill value matter once an op is accepted; the
    // fill is the sign captured at accept since a_q is consumed as it shifts.
    always_comb begin
        op_legal = (bus.in_op == OP_SLL) || (bus.in_op == OP_SRL) || (bus.in_op == OP_SRA);
        pos_sum  = {1'b0, cnt_q} + {1'b0, b_q};

        if (right_q) begin
            shift_bit = (pos_sum > 6'd31) ? fill_q : a_q[b_q];
            shift_en  = (pos_sum <= 6'd31);
        end else begin
            shift_bit = (cnt_q < b_q) ? 1'b0 : a_q[0];
            shift_en  = (cnt_q >= b_q);
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        right_d = right_q;
        fill_d  = fill_q;
        res_d   = res_q;
        err_d   = err_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    a_d     = bus.in_a;
                    b_d     = bus.in_b;
                    right_d = bus.in_op[2];
                    fill_d  = bus.in_op[3] & bus.in_a[31];
                    cnt_d   = 5'd0;
                    res_d   = 32'd0;
                    err_d   = 1'b0;
                    if (!op_legal) begin
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end else if (ZERO_SHAMT_FAST && (bus.in_b == 5'd0)) begin
                        res_d   = bus.in_a;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_SHIFT;
                    end
                end
            end

            ST_SHIFT: begin
                if (bus.abort) begin
                    state_d = ST_IDLE;
                end else begin
                    res_d = {shift_bit, res_q[31:1]};
                    if (shift_en) begin
                        a_d = {1'b0, a_q[31:1]};
                    end
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        state_d = ST_DONE;
                    end
                end
            end

            ST_DONE: begin
                if (bus.abort || bus.out_ready) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 5'd0;
            a_q     <= 32'd0;
            b_q     <= 5'd0;
            right_q <= 1'b0;
            fill_q  <= 1'b0;
            res_q   <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            right_q <= right_d;
            fill_q  <= fill_d;
            res_q   <= res_d;
            err_q   <= err_d;
        end
    end

    assign bus.in_ready  = (state_q == ST_IDLE);
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.bit_valid = (state_q == ST_SHIFT);
    assign bus.bit_out   = (state_q == ST_SHIFT) & shift_bit;
    assign bus.out_valid = (state_q == ST_DONE);
    assign bus.out_d     = res_q;
    assign bus.out_err   = (state_q == ST_DONE) & err_q;

endmodule

// File: tb/tb_nanov_shift_seq.sv
// Randomized and directed bench for nanov_shift_seq, with a behavioural shift model
// and one instance per ZERO_SHAMT_FAST setting.
module tb_nanov_shift_seq;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int errors = 0;
    int checks = 0;

    nanov_shift_seq_if bus0();
    nanov_shift_seq_if bus1();

    nanov_shift_seq #(.ZERO_SHAMT_FAST(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));
    nanov_shift_seq #(.ZERO_SHAMT_FAST(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

    always #5 clk = ~clk;

    // Behavioural model: {err, d} straight from the RV32 shift definitions.
    function automatic logic [32:0] ref_result(input logic [3:0] op, input logic [31:0] a,
                                               input logic [4:0] b);
        logic [31:0] t;
        case (op)
            4'b0001: t = a << b;
            4'b0101: t = a >> b;
            4'b1101: t = $signed(a) >>> b;
            default: return {1'b1, 32'h0};
        endcase
        return {1'b0, t};
    endfunction

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [4:0] b);
        @(negedge clk);
        bus0.in_valid = 1'b1;
        bus0.in_op    = op;
        bus0.in_a     = a;
        bus0.in_b     = b;
        @(negedge clk);
        bus0.in_valid = 1'b0;
    endtask

    // Starts in the first cycle after acceptance; latency 1 means out_valid in that cycle.
    task automatic collect(output int lat, output int nbits, output logic [31:0] stream,
                           output logic [31:0] d, output logic err);
        lat    = -1;
        nbits  = 0;
        stream = 32'h0;
        d      = 32'h0;
        err    = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            if (bus0.bit_valid) begin
                if (nbits < 32) stream[nbits] = bus0.bit_out;
                nbits++;
            end
            if (bus0.out_valid) begin
                lat = k;
                d   = bus0.out_d;
                err = bus0.out_err;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic release_out();
        bus0.out_ready = 1'b1;
        @(negedge clk);
        bus0.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({bus0.in_ready, bus0.busy, bus0.out_valid, bus0.bit_valid, bus0.bit_out, bus0.out_err} !== 6'b100000) begin
            errors++;
            $display("[TB] FAIL reset_flags: got %b expected 100000",
                     {bus0.in_ready, bus0.busy, bus0.out_valid, bus0.bit_valid, bus0.bit_out, bus0.out_err});
        end
        checks++;
        if (bus0.out_d !== 32'h0) begin
            errors++;
            $display("[TB] FAIL reset_out_d: got %h expected 00000000", bus0.out_d);
        end
        bus0.abort = 1'b1;
        @(negedge clk);
        bus0.abort = 1'b0;
        checks++;
        if ({bus0.in_ready, bus0.busy} !== 2'b10) begin
            errors++;
            $display("[TB] FAIL abort_idle: got %b expected 10", {bus0.in_ready, bus0.busy});
        end
    endtask

    task automatic test_sll_edge();
        int lat, nbits;
        logic [31:0] stream, d;
        logic err;
        issue(4'b0001, 32'h0000_0001, 5'd31);
        collect(lat, nbits, stream, d, err);
        checks++;
        if (lat !== 33) begin errors++; $display("[TB] FAIL sll_latency: got %0d expected 33", lat); end
        checks++;
        if (nbits !== 32) begin errors++; $display("[TB] FAIL sll_nbits: got %0d expected 32", nbits); end
        checks++;
        if (stream !== 32'h8000_0000) begin errors++; $display("[TB] FAIL sll_stream: got %h expected 80000000", stream); end
        checks++;
        if ({err, d} !== {1'b0, 32'h8000_0000}) begin
            errors++; $display("[TB] FAIL sll_result: got err=%b d=%h expected err=0 d=80000000", err, d);
        end
        release_out();
    endtask

    task automatic test_right_shifts();
        logic [3:0]  ops [2] = '{4'b1101, 4'b0101};
        logic [31:0] exp [2] = '{32'hF800_000F, 32'h0800_000F};
        int lat, nbits;
        logic [31:0] stream, d;
        logic err;
        for (int i = 0; i < 2; i++) begin
            issue(ops[i], 32'h8000_00F0, 5'd4);
            collect(lat, nbits, stream, d, err);
            checks++;
            if ({err, d} !== {1'b0, exp[i]}) begin
                errors++; $display("[TB] FAIL right_result op=%b: got err=%b d=%h expected d=%h", ops[i], err, d, exp[i]);
            end
            checks++;
            if (stream !== exp[i] || nbits !== 32) begin
                errors++; $display("[TB] FAIL right_stream op=%b: got %h (%0d bits) expected %h", ops[i], stream, nbits, exp[i]);
            end
            release_out();
        end
    endtask

    task automatic test_zero_shamt();
        int lat, nbits;
        logic [31:0] stream, d, a;
        logic err;
        a = $urandom;
        issue(4'b0101, a, 5'd0);
        collect(lat, nbits, stream, d, err);
        checks++;
        if (d !== a || lat !== 33 || nbits !== 32) begin
            errors++; $display("[TB] FAIL zero_slow: got d=%h lat=%0d bits=%0d expected d=%h lat=33 bits=32", d, lat, nbits, a);
        end
        release_out();

        @(negedge clk);
        bus1.in_valid = 1'b1;
        bus1.in_op    = 4'b1101;
        bus1.in_a     = a;
        bus1.in_b     = 5'd0;
        @(negedge clk);
        bus1.in_valid = 1'b0;
        checks++;
        if ({bus1.out_valid, bus1.out_err, bus1.bit_valid, bus1.out_d} !== {3'b100, a}) begin
            errors++; $display("[TB] FAIL zero_fast: got valid=%b err=%b bitv=%b d=%h expected 1 0 0 %h",
                               bus1.out_valid, bus1.out_err, bus1.bit_valid, bus1.out_d, a);
        end
        bus1.out_ready = 1'b1;
        @(negedge clk);
        bus1.out_ready = 1'b0;
        checks++;
        if ({bus1.in_ready, bus1.out_valid} !== 2'b10) begin
            errors++; $display("[TB] FAIL zero_fast_release: got %b expected 10", {bus1.in_ready, bus1.out_valid});
        end
    endtask

    task automatic test_illegal();
        int lat, nbits;
        logic [31:0] stream, d;
        logic err;
        issue(4'b0111, $urandom, 5'($urandom_range(0, 31)));
        collect(lat, nbits, stream, d, err);
        checks++;
        if (lat !== 1 || nbits !== 0) begin
            errors++; $display("[TB] FAIL illegal_timing: got lat=%0d bits=%0d expected lat=1 bits=0", lat, nbits);
        end
        checks++;
        if ({err, d} !== {1'b1, 32'h0}) begin
            errors++; $display("[TB] FAIL illegal_result: got err=%b d=%h expected err=1 d=00000000", err, d);
        end
        release_out();
    endtask

    task automatic test_hold();
        int lat, nbits;
        logic [31:0] stream, d, a, exp;
        logic [4:0] b;
        logic err;
        a = $urandom;
        b = 5'($urandom_range(1, 31));
        exp = ref_result(4'b0001, a, b)[31:0];
        issue(4'b0001, a, b);
        collect(lat, nbits, stream, d, err);
        bus0.in_valid = 1'b1;
        bus0.in_op    = 4'b0101;
        for (int i = 0; i < 10; i++) begin
            checks++;
            if ({bus0.out_valid, bus0.in_ready, bus0.out_d} !== {2'b10, exp}) begin
                errors++; $display("[TB] FAIL hold_cycle%0d: got valid=%b in_ready=%b d=%h expected 1 0 %h",
                                   i, bus0.out_valid, bus0.in_ready, bus0.out_d, exp);
            end
            @(negedge clk);
        end
        bus0.in_valid = 1'b0;
        release_out();
        checks++;
        if ({bus0.in_ready, bus0.out_valid} !== 2'b10) begin
            errors++; $display("[TB] FAIL hold_release: got %b expected 10", {bus0.in_ready, bus0.out_valid});
        end
        a = $urandom;
        issue(4'b0101, a, 5'd7);
        collect(lat, nbits, stream, d, err);
        checks++;
        if (d !== (a >> 7) || lat !== 33) begin
            errors++; $display("[TB] FAIL hold_next: got d=%h lat=%0d expected d=%h lat=33", d, lat, a >> 7);
        end
        release_out();
    endtask

    // Cancels an op at the given counter value, by abort or by reset, then checks recovery.
    task automatic test_cancel(input bit use_rst, input int at_cnt);
        int lat, nbits, seen;
        logic [31:0] stream, d;
        logic err;
        issue(4'b1101, $urandom, 5'($urandom_range(0, 31)));
        repeat (at_cnt) @(negedge clk);
        checks++;
        if (bus0.bit_valid !== 1'b1) begin
            errors++; $display("[TB] FAIL cancel_inflight: got bit_valid=%b expected 1", bus0.bit_valid);
        end
        if (use_rst) rst = 1'b1; else bus0.abort = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus0.abort = 1'b0;
        checks++;
        if ({bus0.busy, bus0.in_ready, bus0.bit_valid, bus0.out_valid} !== 4'b0100) begin
            errors++; $display("[TB] FAIL cancel_idle rst=%0d: got %b expected 0100", use_rst,
                               {bus0.busy, bus0.in_ready, bus0.bit_valid, bus0.out_valid});
        end
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus0.out_valid) seen++;
            @(negedge clk);
        end
        checks++;
        if (seen !== 0) begin errors++; $display("[TB] FAIL cancel_no_valid: got %0d cycles expected 0", seen); end
        issue(4'b0101, 32'hFFFF_FFFF, 5'd1);
        collect(lat, nbits, stream, d, err);
        checks++;
        if ({err, d} !== {1'b0, 32'h7FFF_FFFF} || lat !== 33) begin
            errors++; $display("[TB] FAIL cancel_followup: got err=%b d=%h lat=%0d expected 0 7fffffff 33", err, d, lat);
        end
        release_out();
    endtask

    task automatic test_random();
        logic [3:0]  legal [3] = '{4'b0001, 4'b0101, 4'b1101};
        logic [3:0]  op;
        logic [31:0] a, stream, d;
        logic [4:0]  b;
        logic [32:0] exp;
        logic err;
        int lat, nbits, pick;
        for (int n = 0; n < 25; n++) begin
            pick = $urandom_range(0, 9);
            op = (pick < 9) ? legal[pick % 3] : 4'($urandom);
            a  = $urandom;
            b  = 5'($urandom_range(0, 31));
            exp = ref_result(op, a, b);
            issue(op, a, b);
            collect(lat, nbits, stream, d, err);
            checks++;
            if ({err, d} !== exp) begin
                errors++; $display("[TB] FAIL rand%0d op=%b a=%h b=%0d: got err=%b d=%h expected err=%b d=%h",
                                   n, op, a, b, err, d, exp[32], exp[31:0]);
            end
            checks++;
            if (lat !== (exp[32] ? 1 : 33) || (!exp[32] && stream !== exp[31:0])) begin
                errors++; $display("[TB] FAIL rand%0d_stream: got lat=%0d stream=%h expected lat=%0d stream=%h",
                                   n, lat, stream, exp[32] ? 1 : 33, exp[31:0]);
            end
            repeat ($urandom_range(0, 3)) @(negedge clk);
            checks++;
            if ({bus0.out_valid, bus0.out_d} !== {1'b1, exp[31:0]}) begin
                errors++; $display("[TB] FAIL rand%0d_hold: got valid=%b d=%h expected 1 %h", n, bus0.out_valid, bus0.out_d, exp[31:0]);
            end
            release_out();
        end
    endtask

    task automatic test_back_to_back();
        int first, second;
        first  = -1;
        second = -1;
        @(negedge clk);
        bus0.out_ready = 1'b1;
        bus0.in_valid  = 1'b1;
        bus0.in_op     = 4'b1101;
        bus0.in_a      = $urandom;
        bus0.in_b      = 5'd3;
        for (int c = 0; c < 90; c++) begin
            if (bus0.in_ready) begin
                if (first < 0) first = c;
                else begin second = c; break; end
            end
            @(negedge clk);
        end
        bus0.in_valid  = 1'b0;
        bus0.out_ready = 1'b0;
        checks++;
        if (second - first !== 34 || first < 0 || second < 0) begin
            errors++; $display("[TB] FAIL issue_interval: got first=%0d second=%0d expected spacing 34", first, second);
        end
    endtask

    initial begin
        bus0.in_valid = 1'b0; bus0.in_op = 4'h0; bus0.in_a = 32'h0; bus0.in_b = 5'h0;
        bus0.abort = 1'b0; bus0.out_ready = 1'b0;
        bus1.in_valid = 1'b0; bus1.in_op = 4'h0; bus1.in_a = 32'h0; bus1.in_b = 5'h0;
        bus1.abort = 1'b0; bus1.out_ready = 1'b0;

        test_reset();
        test_sll_edge();
        test_right_shifts();
        test_zero_shamt();
        test_illegal();
        test_hold();
        test_cancel(1'b0, 12);
        test_cancel(1'b1, 20);
        test_random();
        test_back_to_back();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
